// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: op codes, output-buffer state
// and the per-bit evaluation of the bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_NAND = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Illegal op codes evaluate to 0 so the result word is forced to zero.
  function automatic logic lu_bit(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op > OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_grant.sv
// Combinational round-robin grant: first set request at or after ptr wins,
// searching modulo NUM_REQ.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(ptr) + k) % NUM_REQ;
        if (!any && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 32-bit bitwise logic unit with a one-entry registered output.
// Optional grant statistics counter enabled by LOGIC_UNIT_ARB_STATS_EN.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_zero,
  output logic                    rsp_err
`ifdef LOGIC_UNIT_ARB_STATS_EN
  ,
  output logic [15:0]             grant_count
`endif
);

  buf_state_t          state_p1;
  logic [ID_W-1:0]     ptr_p1;
  logic [WIDTH-1:0]    data_p1;
  logic [ID_W-1:0]     id_p1;
  logic                zero_p1;
  logic                err_p1;

  logic                can_accept_p0;
  logic [NUM_REQ-1:0]  grant_p0;
  logic [ID_W-1:0]     idx_p0;
  logic                any_p0;
  logic [WIDTH-1:0]    a_p0;
  logic [WIDTH-1:0]    b_p0;
  logic [OP_W-1:0]     op_p0;
  logic [WIDTH-1:0]    res_p0;
  logic                err_p0;
  logic [ID_W-1:0]     ptr_next_p0;

  // Stage p0: arbitration, operand select and logic evaluation
  assign can_accept_p0 = (state_p1 == BUF_EMPTY) || rsp_ready;

  rr_grant #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (ID_W)
  ) u_rr_grant (
    .req  (req_valid),
    .ptr  (ptr_p1),
    .en   (can_accept_p0 && !reset),
    .grant(grant_p0),
    .idx  (idx_p0),
    .any  (any_p0)
  );

  assign req_ready = grant_p0;

  always_comb begin
    a_p0  = '0;
    b_p0  = '0;
    op_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_p0[i]) begin
        a_p0  = req_a[i*WIDTH +: WIDTH];
        b_p0  = req_b[i*WIDTH +: WIDTH];
        op_p0 = req_op[i*OP_W +: OP_W];
      end
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign res_p0[k] = lu_bit(op_p0, a_p0[k], b_p0[k]);
  end

  assign err_p0      = op_illegal(op_p0);
  assign ptr_next_p0 = (idx_p0 == ID_W'(NUM_REQ - 1)) ? '0 : idx_p0 + 1'b1;

  // Stage p1: output buffer, state and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= BUF_EMPTY;
      ptr_p1   <= '0;
      data_p1  <= '0;
      id_p1    <= '0;
      zero_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else if (any_p0) begin
      state_p1 <= BUF_FULL;
      ptr_p1   <= ptr_next_p0;
      data_p1  <= res_p0;
      id_p1    <= idx_p0;
      zero_p1  <= (res_p0 == '0);
      err_p1   <= err_p0;
    end else if (state_p1 == BUF_FULL && rsp_ready) begin
      state_p1 <= BUF_EMPTY;
    end
  end

  assign rsp_valid = (state_p1 == BUF_FULL);
  assign rsp_data  = data_p1;
  assign rsp_id    = id_p1;
  assign rsp_zero  = zero_p1;
  assign rsp_err   = err_p1;

`ifdef LOGIC_UNIT_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_count <= '0;
    end else if (any_p0) begin
      grant_count <= sat_inc16(grant_count);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*3-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [IW-1:0]    rsp_id;
  logic             rsp_zero;
  logic             rsp_err;
`ifdef LOGIC_UNIT_ARB_STATS_EN
  logic [15:0]      grant_count;
`endif

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
`ifdef LOGIC_UNIT_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester-side pending transactions
  logic        va[N];
  logic [31:0] aa[N];
  logic [31:0] ba[N];
  logic [2:0]  oa[N];

  // Reference model of the arbiter
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  bit          m_zero;
  bit          m_err;
  int          m_ptr;
  int          m_g;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, ~(a & b)};
      3'd2: return {1'b0, a | b};
      3'd3: return {1'b0, ~(a | b)};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~(a ^ b)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = va[i];
      req_a[i*W +: W]    = aa[i];
      req_b[i*W +: W]    = ba[i];
      req_op[i*3 +: 3]   = oa[i];
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_data = 0; m_id = 0; m_zero = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      va[i] = 0; aa[i] = 0; ba[i] = 0; oa[i] = 0;
    end
  endtask

  // One clock cycle: called just after a falling edge with inputs prepared.
  task automatic cycle();
    logic [32:0] r;
    logic [N-1:0] exp_ready;
    drive();
    #1;
    m_g = -1;
    if (!m_full || rsp_ready) begin
      for (int k = 0; k < N; k++) begin
        if (m_g < 0 && va[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (m_g >= 0) exp_ready[m_g] = 1'b1;
    chk("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
    @(posedge clk);
    if (m_g >= 0) begin
      r      = ref_op(oa[m_g], aa[m_g], ba[m_g]);
      m_err  = r[32];
      m_data = r[31:0];
      m_zero = (m_data == 0);
      m_id   = m_g;
      m_full = 1;
      m_ptr  = (m_g + 1) % N;
      va[m_g] = 0;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_full});
    if (m_full) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id",   {30'h0, rsp_id}, m_id);
      chk("rsp_zero", {31'h0, rsp_zero}, {31'h0, m_zero});
      chk("rsp_err",  {31'h0, rsp_err}, {31'h0, m_err});
    end
`ifdef LOGIC_UNIT_ARB_STATS_EN
    chk("grant_count", {16'h0, grant_count}, m_cnt);
`endif
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'h0, rsp_valid}, 0);
    chk({tag, "_data"},  rsp_data, 0);
    chk({tag, "_id"},    {30'h0, rsp_id}, 0);
    chk({tag, "_zero"},  {31'h0, rsp_zero}, 0);
    chk({tag, "_err"},   {31'h0, rsp_err}, 0);
    chk({tag, "_ready"}, {28'h0, req_ready}, 0);
  endtask

  initial begin
    // Reset with every requester asking: nothing may be granted.
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = 1; aa[i] = $urandom; ba[i] = $urandom; oa[i] = 3'($urandom_range(0, 5));
    end
    drive();
    #2;
    chk_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Fairness: all four valid, grants rotate 0,1,2,3,0,1
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!va[i]) begin
          va[i] = 1; aa[i] = $urandom; ba[i] = $urandom; oa[i] = 3'($urandom_range(0, 5));
        end
      end
      cycle();
      chk("fair_id", {30'h0, rsp_id}, c % 4);
    end

    // Single NAND request from requester 0
    clear_reqs();
    va[0] = 1; aa[0] = 32'hFFFF0000; ba[0] = 32'h0F0F0F0F; oa[0] = 3'd1;
    cycle();
    chk("nand_valid", {31'h0, rsp_valid}, 1);
    chk("nand_data", rsp_data, 32'hF0F0FFFF);
    chk("nand_id", {30'h0, rsp_id}, 0);
    chk("nand_zero", {31'h0, rsp_zero}, 0);

    // Backpressure: FULL and stalled while requester 2 waits
    rsp_ready = 1'b0;
    va[2] = 1; aa[2] = 32'h00FF00FF; ba[2] = 32'h0000FFFF; oa[2] = 3'd2;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_hold", rsp_data, 32'hF0F0FFFF);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_id", {30'h0, rsp_id}, 2);
    chk("bp_release_data", rsp_data, 32'h00FFFFFF);

    // Illegal op
    va[1] = 1; aa[1] = 32'hDEADBEEF; ba[1] = 32'h12345678; oa[1] = 3'd7;
    cycle();
    chk("ill_err", {31'h0, rsp_err}, 1);
    chk("ill_data", rsp_data, 0);
    chk("ill_zero", {31'h0, rsp_zero}, 1);

    // XOR of equal operands gives zero
    va[3] = 1; aa[3] = 32'h12345678; ba[3] = 32'h12345678; oa[3] = 3'd4;
    cycle();
    chk("xor_data", rsp_data, 0);
    chk("xor_zero", {31'h0, rsp_zero}, 1);
    chk("xor_err", {31'h0, rsp_err}, 0);

    // Put pointer at 3 with the buffer FULL, then reset mid-operation
    va[2] = 1; aa[2] = 32'hA5A5A5A5; ba[2] = 32'hFFFFFFFF; oa[2] = 3'd0;
    cycle();
    chk("pre_rst_valid", {31'h0, rsp_valid}, 1);
    va[0] = 1; va[3] = 1;
    drive();
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("post_rst_id", {30'h0, rsp_id}, 0);
    cycle();
    chk("post_rst_id2", {30'h0, rsp_id}, 3);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!va[i] && ($urandom_range(0, 2) != 0)) begin
          va[i] = 1;
          aa[i] = $urandom;
          ba[i] = ($urandom_range(0, 7) == 0) ? aa[i] : $urandom;
          oa[i] = 3'($urandom_range(0, 7));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

`ifdef LOGIC_UNIT_ARB_STATS_EN
    // Saturation of the grant counter
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = 1; aa[i] = $urandom; ba[i] = $urandom; oa[i] = 3'd0;
    end
    drive();
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_sat", {16'h0, grant_count}, 32'h0000FFFF);
    reset = 1'b1;
    #1;
    chk("cnt_rst", {16'h0, grant_count}, 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
